// File: rtl/loop_pkg.sv
// Shared types and default sizing for the audio loop sequencer.
package loop_pkg;

  localparam int unsigned LOOP_ADDR_W  = 16;
  localparam int unsigned LOOP_MAX_LEN = 48000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } loop_state_t;

endpackage

// File: rtl/loop_sequencer_if.sv
// Codec handshake and sample RAM control signals of the loop sequencer.
interface loop_sequencer_if
  import loop_pkg::*;
#(
  parameter int unsigned ADDR_W = LOOP_ADDR_W
);

  logic              read_ready;
  logic              write_ready;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;

  // Sequencer side.
  modport master (
    input  read_ready,
    input  write_ready,
    output read,
    output write,
    output mem_addr,
    output mem_we
  );

  // Codec / memory side.
  modport slave (
    output read_ready,
    output write_ready,
    input  read,
    input  write,
    input  mem_addr,
    input  mem_we
  );

endinterface

// File: rtl/loop_addr_counter.sv
// Up/down address counter with load, enable and wrap at i_limit (range 0..i_limit).
module loop_addr_counter
  import loop_pkg::*;
#(
  parameter int unsigned Width = LOOP_ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_up,
  input  logic [Width-1:0] i_limit,
  output logic [Width-1:0] o_count,
  output logic [Width-1:0] o_next
);

  logic [Width-1:0] r_count;

  // Value the counter takes on the next enabled step, wrapping at both ends.
  always_comb begin
    o_next = r_count;
    if (i_up) begin
      o_next = (r_count == i_limit) ? '0 : r_count + Width'(1);
    end else begin
      o_next = (r_count == '0) ? i_limit : r_count - Width'(1);
    end
  end

  // Load has priority over stepping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= o_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/loop_sequencer.sv
// Record/play/idle sequencer: codec strobes, sample RAM address and write enable.
module loop_sequencer
  import loop_pkg::*;
#(
  parameter int unsigned ADDR_W  = LOOP_ADDR_W,
  parameter int unsigned MAX_LEN = LOOP_MAX_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_btn,
  input  logic              reverse,
  loop_sequencer_if.master  bus,
  output logic              play_sel,
  output logic [ADDR_W:0]   loop_len,
  output logic [1:0]        state
);

  localparam logic [1:0] StIdle   = IDLE;
  localparam logic [1:0] StRecord = RECORD;
  localparam logic [1:0] StPlay   = PLAY;

  localparam logic [ADDR_W-1:0] RecLast = ADDR_W'(MAX_LEN - 1);

  logic              r_btn_prev;
  logic              r_strobe;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_play_sel;
  logic [ADDR_W:0]   r_loop_len;
  logic [1:0]        r_state;
  logic              r_play_first;

  logic              w_press;
  logic              w_tick;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W:0]   w_len_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_we_nxt;
  logic              w_play_first_nxt;

  logic              w_rec_load;
  logic              w_rec_en;
  logic [ADDR_W-1:0] w_rec_ptr;
  logic [ADDR_W-1:0] w_unused_rec_next;
  logic [ADDR_W:0]   w_rec_len;

  logic              w_play_load;
  logic [ADDR_W-1:0] w_play_load_val;
  logic              w_play_en;
  logic [ADDR_W-1:0] w_play_ptr;
  logic [ADDR_W-1:0] w_play_next;
  logic [ADDR_W-1:0] w_play_limit;
  logic              w_unused_len_msb;

  assign w_press = rec_btn & ~r_btn_prev;
  assign w_tick  = bus.read_ready & bus.write_ready & ~r_strobe;

  // Length of the take if recording stops now; includes a sample written this cycle.
  assign w_rec_len = {1'b0, w_rec_ptr} + (ADDR_W + 1)'(w_tick);

  // loop_len >= 1 whenever PLAY uses this limit.
  assign {w_unused_len_msb, w_play_limit} = r_loop_len - (ADDR_W + 1)'(1);

  loop_addr_counter #(
    .Width (ADDR_W)
  ) u_rec_ptr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_rec_load),
    .i_load_val ('0),
    .i_en       (w_rec_en),
    .i_up       (1'b1),
    .i_limit    (RecLast),
    .o_count    (w_rec_ptr),
    .o_next     (w_unused_rec_next)
  );

  loop_addr_counter #(
    .Width (ADDR_W)
  ) u_play_ptr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_play_load),
    .i_load_val (w_play_load_val),
    .i_en       (w_play_en),
    .i_up       (~reverse),
    .i_limit    (w_play_limit),
    .o_count    (w_play_ptr),
    .o_next     (w_play_next)
  );

  // FSM next state; a same-cycle tick is serviced before the transition applies.
  always_comb begin
    w_state_nxt      = r_state;
    w_len_nxt        = r_loop_len;
    w_addr_nxt       = r_mem_addr;
    w_we_nxt         = 1'b0;
    w_play_first_nxt = r_play_first;
    w_rec_load       = 1'b0;
    w_rec_en         = 1'b0;
    w_play_load      = 1'b0;
    w_play_load_val  = '0;
    w_play_en        = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_press) begin
          w_state_nxt = StRecord;
          w_rec_load  = 1'b1;
        end
      end
      StRecord: begin
        if (w_tick) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = w_rec_ptr;
          w_rec_en   = 1'b1;
        end
        // Auto-stop consumes a simultaneous press.
        if ((w_tick && (w_rec_ptr == RecLast)) ||
            (w_press && (w_tick || (w_rec_ptr != '0)))) begin
          w_state_nxt      = StPlay;
          w_len_nxt        = w_rec_len;
          w_play_load      = 1'b1;
          w_play_first_nxt = 1'b1;
          // Reverse starts at the last sample written, i.e. w_rec_len - 1.
          if (reverse) begin
            w_play_load_val = w_tick ? w_rec_ptr : w_rec_ptr - ADDR_W'(1);
          end
        end else if (w_press) begin
          w_state_nxt = StIdle;
        end
      end
      StPlay: begin
        if (w_tick) begin
          w_play_first_nxt = 1'b0;
          // The pointer holds the last address read, so a direction change
          // steps away from it in the new direction.
          if (r_play_first) begin
            w_addr_nxt = w_play_ptr;
          end else begin
            w_play_en  = 1'b1;
            w_addr_nxt = w_play_next;
          end
        end
        if (w_press) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Registered state and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_prev   <= 1'b0;
      r_strobe     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_play_sel   <= 1'b0;
      r_loop_len   <= '0;
      r_state      <= StIdle;
      r_play_first <= 1'b0;
    end else begin
      r_btn_prev   <= rec_btn;
      r_strobe     <= w_tick;
      r_mem_we     <= w_we_nxt;
      r_mem_addr   <= w_addr_nxt;
      r_play_sel   <= (w_state_nxt == StPlay);
      r_loop_len   <= w_len_nxt;
      r_state      <= w_state_nxt;
      r_play_first <= w_play_first_nxt;
    end
  end

  assign bus.read     = r_strobe;
  assign bus.write    = r_strobe;
  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign play_sel     = r_play_sel;
  assign loop_len     = r_loop_len;
  assign state        = r_state;

endmodule

// File: tb/tb_loop_sequencer.sv
// Self-checking bench for loop_sequencer: vector table plus strobe scoreboard.
module tb_loop_sequencer;
  import loop_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned ML = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          rec_btn;
  logic          reverse;
  logic          play_sel;
  logic [AW:0]   loop_len;
  logic [1:0]    state;

  loop_sequencer_if #(.ADDR_W(AW)) bus ();

  loop_sequencer #(
    .ADDR_W  (AW),
    .MAX_LEN (ML)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rec_btn  (rec_btn),
    .reverse  (reverse),
    .bus      (bus),
    .play_sel (play_sel),
    .loop_len (loop_len),
    .state    (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic          chk_addr;
  } exp_t;

  typedef struct {
    logic          press;
    logic          rev;
    logic          tick;
    logic          we;
    logic [AW-1:0] addr;
    logic          chk_addr;
    logic [1:0]    st;
    logic          ps;
    logic [AW:0]   len;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; a strobe must appear exactly when a tick was driven before the edge.
  task automatic step(input logic exp_strobe);
    exp_t e;
    @(posedge clk);
    #1;
    chk("strobe", 32'(bus.read), 32'(exp_strobe));
    chk("write_with_read", 32'(bus.write), 32'(bus.read));
    if (exp_strobe && sb.size() > 0) begin
      e = sb.pop_front();
      if (bus.read) begin
        chk("mem_we", 32'(bus.mem_we), 32'(e.we));
        if (e.chk_addr) chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
      end
    end else begin
      chk("mem_we_quiet", 32'(bus.mem_we), 32'd0);
    end
  endtask

  task automatic add(input logic press, input logic rev, input logic tick, input logic we,
                     input int addr, input logic chk_addr, input int st, input logic ps,
                     input int len);
    vec_t v;
    v.press = press; v.rev = rev; v.tick = tick; v.we = we;
    v.addr = AW'(addr); v.chk_addr = chk_addr; v.st = 2'(st); v.ps = ps;
    v.len = (AW + 1)'(len);
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    rec_btn = v.press;
    reverse = v.rev;
    bus.read_ready  = v.tick;
    bus.write_ready = v.tick;
    if (v.tick) begin
      e.we = v.we; e.addr = v.addr; e.chk_addr = v.chk_addr;
      sb.push_back(e);
    end
    step(v.tick);
    rec_btn = 1'b0;
    bus.read_ready  = 1'b0;
    bus.write_ready = 1'b0;
    step(1'b0);
    chk("state", 32'(state), 32'(v.st));
    chk("loop_len", 32'(loop_len), 32'(v.len));
    chk("play_sel", 32'(play_sel), 32'(v.ps));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_read"}, 32'(bus.read), 32'd0);
    chk({tag, "_write"}, 32'(bus.write), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_play_sel"}, 32'(play_sel), 32'd0);
    chk({tag, "_loop_len"}, 32'(loop_len), 32'd0);
    chk({tag, "_state"}, 32'(state), 32'd0);
  endtask

  initial begin
    int   n_strobe;
    logic prev_read;
    reset = 1'b1;
    rec_btn = 1'b0;
    reverse = 1'b0;
    bus.read_ready  = 1'b0;
    bus.write_ready = 1'b0;
    #12;
    chk_reset_outputs("reset");
    reset = 1'b0;

    // press, rev, tick, we, addr, chk_addr, state, play_sel, loop_len
    for (int i = 0; i < 10; i++) add(0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Record 5, play forward with wrap.
    add(1, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 1, i, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 2, 1, 5);
    for (int i = 0; i < 7; i++) add(0, 0, 1, 0, i % 5, 1, 2, 1, 5);
    add(1, 0, 0, 0, 0, 0, 0, 0, 5);
    // Record 5, reverse play, flip to forward after reading 2.
    add(1, 0, 0, 0, 0, 0, 1, 0, 5);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 1, i, 1, 1, 0, 5);
    add(1, 1, 0, 0, 0, 0, 2, 1, 5);
    add(0, 1, 1, 0, 4, 1, 2, 1, 5);
    add(0, 1, 1, 0, 3, 1, 2, 1, 5);
    add(0, 1, 1, 0, 2, 1, 2, 1, 5);
    add(0, 0, 1, 0, 3, 1, 2, 1, 5);
    add(0, 0, 1, 0, 4, 1, 2, 1, 5);
    add(0, 0, 1, 0, 0, 1, 2, 1, 5);
    add(1, 0, 0, 0, 0, 0, 0, 0, 5);
    // Empty take returns to IDLE, length kept.
    add(1, 0, 0, 0, 0, 0, 1, 0, 5);
    add(1, 0, 0, 0, 0, 0, 0, 0, 5);
    // Auto-stop at MAX_LEN.
    add(1, 0, 0, 0, 0, 0, 1, 0, 5);
    for (int i = 0; i < 7; i++) add(0, 0, 1, 1, i, 1, 1, 0, 5);
    add(0, 0, 1, 1, 7, 1, 2, 1, 8);
    add(0, 0, 1, 0, 0, 1, 2, 1, 8);
    add(1, 0, 0, 0, 0, 0, 0, 0, 8);
    // Press on the auto-stop tick is consumed.
    add(1, 0, 0, 0, 0, 0, 1, 0, 8);
    for (int i = 0; i < 7; i++) add(0, 0, 1, 1, i, 1, 1, 0, 8);
    add(1, 0, 1, 1, 7, 1, 2, 1, 8);
    add(0, 0, 1, 0, 0, 1, 2, 1, 8);
    add(1, 0, 0, 0, 0, 0, 0, 0, 8);
    // Press with tick: length includes that sample; reverse wrap on a 2-sample loop.
    add(1, 0, 0, 0, 0, 0, 1, 0, 8);
    add(0, 0, 1, 1, 0, 1, 1, 0, 8);
    add(1, 1, 1, 1, 1, 1, 2, 1, 2);
    add(0, 1, 1, 0, 1, 1, 2, 1, 2);
    add(0, 1, 1, 0, 0, 1, 2, 1, 2);
    add(0, 1, 1, 0, 1, 1, 2, 1, 2);
    add(1, 0, 0, 0, 0, 0, 0, 0, 2);

    foreach (vecs[i]) apply(vecs[i]);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    // Enter PLAY, then reset asynchronously mid-cycle.
    add(1, 0, 0, 0, 0, 0, 1, 0, 2);
    apply(vecs[vecs.size() - 1]);
    add(0, 0, 1, 1, 0, 1, 1, 0, 2);
    apply(vecs[vecs.size() - 1]);
    add(1, 0, 0, 0, 0, 0, 2, 1, 1);
    apply(vecs[vecs.size() - 1]);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    bus.read_ready  = 1'b1;
    bus.write_ready = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("no_strobe_after_release", 32'(bus.read), 32'd0);

    // Ready held high: strobes alternate with idle cycles.
    n_strobe = 0;
    prev_read = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("strobe_gap", 32'(prev_read & bus.read), 32'd0);
      chk("idle_no_we", 32'(bus.mem_we), 32'd0);
      if (bus.read) n_strobe++;
      prev_read = bus.read;
    end
    chk("strobe_count", 32'(n_strobe), 32'd10);
    chk("idle_state", 32'(state), 32'd0);
    bus.read_ready  = 1'b0;
    bus.write_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/loop_sequencer.md
# loop_sequencer

Control sequencer for the audio loop recorder: it watches the codec's `read_ready`/`write_ready` flags, issues single-cycle `read`/`write` strobes, and drives the address and write-enable of the shared sample RAM. It runs the record → play → idle cycle from one record button, with forward or reverse playback. One instance serves both channels. It sits between the codec and the per-channel sample memories, which hold only storage and the output mux.

## Interface
Parameters:
- `ADDR_W`, 16: sample RAM address width.
- `MAX_LEN`, 48000: maximum loop length in samples; must be ≤ 2^ADDR_W.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-high; one clock domain.
- `rec_btn` in 1: record button, active-high, already synchronised; only its rising edge is used.
- `reverse` in 1: playback direction; 1 = reverse.
- `read_ready` in 1: codec has an input sample.
- `write_ready` in 1: codec can accept an output sample.
- `read` out 1: one-cycle strobe that consumes one codec input sample.
- `write` out 1: one-cycle strobe that sends one codec output sample.
- `mem_addr` out ADDR_W: sample RAM address.
- `mem_we` out 1: sample RAM write enable.
- `play_sel` out 1: output mux select; 0 = pass input through, 1 = RAM read data.
- `loop_len` out ADDR_W+1: length of the recorded loop in samples.
- `state` out 2: current state, for debug and LEDs.

## Operation
- States:
  - IDLE = 0: pass-through, `play_sel` = 0.
  - RECORD = 1: samples written to RAM.
  - PLAY = 2: samples read from RAM, `play_sel` = 1.
- Encoding 3 is unreachable and recovers to IDLE.
- `press` is the rising edge of `rec_btn`, taken from a registered copy of the previous value.
- `tick` = `read_ready & write_ready & ~strobe_q`. Every tick asserts `read` and `write` together in all states, so the codec never stalls.
- IDLE:
  - `press` → RECORD, with the record pointer set to 0.
- RECORD:
  - Each tick: `mem_we` = 1 at `mem_addr` = pointer, then pointer increments.
  - `press` with pointer = 0 → IDLE (empty take).
  - `press` with pointer > 0 → PLAY, `loop_len` = pointer.
  - A tick that writes address MAX_LEN−1 → PLAY, `loop_len` = MAX_LEN (auto-stop).
  - On any entry to PLAY, the play pointer is set to 0 when `reverse` = 0, or to `loop_len`−1 when `reverse` = 1.
- PLAY:
  - Each tick: `mem_addr` = play pointer, `mem_we` = 0.
  - Forward: the pointer increments and wraps from `loop_len`−1 to 0.
  - Reverse: the pointer decrements and wraps from 0 to `loop_len`−1.
  - Changing `reverse` mid-loop takes effect at the next tick; the pointer is not reset.
  - `press` → IDLE. `loop_len` is retained, and the next record overwrites it.
- Arithmetic: all pointer arithmetic is unsigned. The record pointer must never exceed MAX_LEN−1.

## Timing
- Reset value of every output: `read` = 0, `write` = 0, `mem_we` = 0, `mem_addr` = 0, `play_sel` = 0, `loop_len` = 0, `state` = IDLE.
- All outputs are registered.
- `read`, `write` and `mem_we` assert in the cycle after the tick condition and last exactly 1 cycle.
- `strobe_q` enforces at least 1 idle cycle between strobes.
- `mem_addr` is valid in the same cycle as the strobe. The RAM has 1-cycle read latency, so RAM data reaches the codec path 1 cycle after the strobe. The downstream output register absorbs this.
- `press` and tick in the same cycle: the tick is serviced by the current state's rule, then the transition applies. Example: a RECORD tick writes its sample, then `loop_len` includes that sample.
- `press` together with auto-stop in RECORD → PLAY; the press is consumed.
- `reset` asserted mid-record or mid-play returns to IDLE immediately. RAM contents are untouched but `loop_len` = 0.

## Structure
- Package `loop_pkg`:
  - state enum `loop_state_t` (IDLE, RECORD, PLAY);
  - default `MAX_LEN`;
  - `ADDR_W` default.
- Natural sub-module: `loop_addr_counter`. It is an up/down counter with load, wrap-at-`limit` and enable ports, used for both the record and play pointers.
- The FSM, edge detect and strobe generation stay in `loop_sequencer`.

## Test plan
- Reset then 10 ticks in IDLE → 10 `read`/`write` pulses, `mem_we` = 0 throughout, `play_sel` = 0.
- Press, 5 ticks, press → writes at addresses 0–4, `loop_len` = 5, `state` = PLAY. The next 7 ticks read addresses 0,1,2,3,4,0,1.
- Record 5 samples, reverse = 1, press → PLAY reads 4,3,2,1,0,4. Toggle `reverse` to 0 after reading 2 → the next reads are 3,4,0.
- MAX_LEN = 8, press, 8 ticks with no second press → auto-stop, `loop_len` = 8. A press on the same cycle as the last tick gives the same result.
- Press, then press again with no ticks → back to IDLE, `loop_len` unchanged, no RAM writes.
- Assert `reset` during PLAY → all outputs return to their reset values asynchronously, with no strobe in the cycle after release. Also check `read_ready` held high continuously → strobes occur at most every other cycle.
